// File: rtl/hdmi_timing_pkg.sv
// hdmi_timing_pkg: shared 720p60 timing defaults, widths and pixel type for
// the HDMI timing generator slice.
package hdmi_timing_pkg;

   localparam int unsigned CNT_W = 12;
   localparam int unsigned RGB_W = 24;

   typedef logic [RGB_W-1:0] rgb_t;

   localparam int unsigned H_ACTIVE_720P = 1280;
   localparam int unsigned H_FP_720P     = 110;
   localparam int unsigned H_SYNC_720P   = 40;
   localparam int unsigned H_BP_720P     = 220;
   localparam int unsigned V_ACTIVE_720P = 720;
   localparam int unsigned V_FP_720P     = 5;
   localparam int unsigned V_SYNC_720P   = 5;
   localparam int unsigned V_BP_720P     = 20;

   localparam int unsigned H_TOTAL_720P = H_ACTIVE_720P + H_FP_720P + H_SYNC_720P + H_BP_720P;
   localparam int unsigned V_TOTAL_720P = V_ACTIVE_720P + V_FP_720P + V_SYNC_720P + V_BP_720P;

   // True when lo <= cnt < hi; widened to 32 bits so mixed-width compares stay clean.
   function automatic logic in_range(input logic [CNT_W-1:0] cnt,
                                     input int unsigned lo,
                                     input int unsigned hi);
      return (32'(cnt) >= lo) && (32'(cnt) < hi);
   endfunction

endpackage

// File: rtl/hdmi_timing_gen_timing_counter.sv
// timing_counter: modulo-MOD up-counter with enable, synchronous active-high
// reset and a terminal-count flag (count == MOD-1).
module timing_counter
   import hdmi_timing_pkg::*;
#(
   parameter int unsigned MOD = H_TOTAL_720P
)(
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_en,
   output logic [CNT_W-1:0] o_count,
   output logic             o_tc
);

   logic [CNT_W-1:0] r_count;
   logic             w_tc;

   assign w_tc    = (32'(r_count) == (MOD - 1));
   assign o_count = r_count;
   assign o_tc    = w_tc;

   // Advance when enabled, wrapping to zero after the terminal count.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= w_tc ? '0 : r_count + 1'b1;
      end
   end

endmodule

// File: rtl/hdmi_timing_gen.sv
// hdmi_timing_gen: raster timing generator (default 1280x720@60). Exposes the
// scan coordinates to the colour stage and registers rgb/de/hsync/vsync one
// clock later so all encoder-side outputs stay mutually aligned.
// Optional: define HDMI_TIMING_FRAME_START_EN to add the frame_start pulse.
module hdmi_timing_gen
   import hdmi_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = H_ACTIVE_720P,
   parameter int unsigned H_FP     = H_FP_720P,
   parameter int unsigned H_SYNC   = H_SYNC_720P,
   parameter int unsigned H_BP     = H_BP_720P,
   parameter int unsigned V_ACTIVE = V_ACTIVE_720P,
   parameter int unsigned V_FP     = V_FP_720P,
   parameter int unsigned V_SYNC   = V_SYNC_720P,
   parameter int unsigned V_BP     = V_BP_720P,
   parameter logic        HS_POL   = 1'b1,
   parameter logic        VS_POL   = 1'b1
)(
   input  logic             clk,
   input  logic             reset,
   output logic [CNT_W-1:0] hcount,
   output logic [CNT_W-1:0] vcount,
   input  logic [RGB_W-1:0] disp_data,
   output logic [RGB_W-1:0] rgb,
   output logic             de,
   output logic             hsync,
`ifdef HDMI_TIMING_FRAME_START_EN
   output logic             vsync,
   output logic             frame_start
`else
   output logic             vsync
`endif
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   logic [CNT_W-1:0] w_h_cnt;
   logic [CNT_W-1:0] w_v_cnt;
   logic             w_h_tc;
   logic             w_v_tc;
   logic             w_active;
   logic             w_hs_region;
   logic             w_vs_region;

   rgb_t             r_rgb;
   logic             r_de;
   logic             r_hsync;
   logic             r_vsync;

   timing_counter #(.MOD(H_TOTAL)) u_h_cnt (
      .i_clk   (clk),
      .i_reset (reset),
      .i_en    (1'b1),
      .o_count (w_h_cnt),
      .o_tc    (w_h_tc)
   );

   // The line counter steps only on the last pixel of a line, so both wrap together at frame end.
   timing_counter #(.MOD(V_TOTAL)) u_v_cnt (
      .i_clk   (clk),
      .i_reset (reset),
      .i_en    (w_h_tc),
      .o_count (w_v_cnt),
      .o_tc    (w_v_tc)
   );

   assign hcount = w_h_cnt;
   assign vcount = w_v_cnt;

   assign w_active    = in_range(w_h_cnt, 0, H_ACTIVE) && in_range(w_v_cnt, 0, V_ACTIVE);
   assign w_hs_region = in_range(w_h_cnt, H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC);
   assign w_vs_region = in_range(w_v_cnt, V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC);

   // Pixel-side register stage: one clock behind hcount/vcount, blanking forces black.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_de    <= 1'b0;
         r_rgb   <= '0;
         r_hsync <= ~HS_POL;
         r_vsync <= ~VS_POL;
      end else begin
         r_de    <= w_active;
         r_rgb   <= w_active ? disp_data : '0;
         r_hsync <= w_hs_region ? HS_POL : ~HS_POL;
         r_vsync <= w_vs_region ? VS_POL : ~VS_POL;
      end
   end

   assign rgb   = r_rgb;
   assign de    = r_de;
   assign hsync = r_hsync;
   assign vsync = r_vsync;

`ifdef HDMI_TIMING_FRAME_START_EN
   logic r_frame_start;

   // Single-clock marker registered alongside pixel (0,0).
   always_ff @(posedge clk) begin
      if (reset) begin
         r_frame_start <= 1'b0;
      end else begin
         r_frame_start <= (w_h_cnt == '0) && (w_v_cnt == '0);
      end
   end

   assign frame_start = r_frame_start;
`endif

   // Frame end must return both coordinates to the origin on the same edge.
   a_frame_wrap: assert property (@(posedge clk) disable iff (reset)
      (w_h_tc && w_v_tc) |=> ((w_h_cnt == '0) && (w_v_cnt == '0)));

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// tb_hdmi_timing_gen: scoreboard bench for hdmi_timing_gen using a reduced
// raster so several whole frames fit in a short run.
module tb_hdmi_timing_gen;

   localparam int unsigned HA  = 16;
   localparam int unsigned HFP = 3;
   localparam int unsigned HS  = 4;
   localparam int unsigned HBP = 5;
   localparam int unsigned VA  = 6;
   localparam int unsigned VFP = 2;
   localparam int unsigned VS  = 2;
   localparam int unsigned VBP = 3;
   localparam int unsigned HT  = HA + HFP + HS + HBP;   // 28
   localparam int unsigned VT  = VA + VFP + VS + VBP;   // 13
   localparam int unsigned FT  = HT * VT;               // 364

   typedef struct packed {
      logic        de;
      logic [23:0] rgb;
      logic        hs;
      logic        vs;
      logic        fs;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [11:0] hcount;
   logic [11:0] vcount;
   logic [23:0] disp_data;
   logic [23:0] rgb;
   logic        de;
   logic        hsync;
   logic        vsync;
   logic        fs_obs;
   logic        const_mode = 1'b0;
   logic [27:0] obs;

   int          errors = 0;
   int          checks = 0;
   int unsigned mh = 0;
   int unsigned mv = 0;
   exp_t        sbq[$];

   always #5 clk = ~clk;

   assign disp_data = const_mode ? 24'hFF0000 : {hcount, vcount};

`ifdef HDMI_TIMING_FRAME_START_EN
   logic frame_start;
   assign fs_obs = frame_start;
`else
   assign fs_obs = 1'b0;
`endif

   assign obs = {de, rgb, hsync, vsync, fs_obs};

   hdmi_timing_gen #(
      .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
      .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
      .HS_POL   (1'b1), .VS_POL (1'b1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .hcount      (hcount),
      .vcount      (vcount),
      .disp_data   (disp_data),
      .rgb         (rgb),
      .de          (de),
      .hsync       (hsync),
`ifdef HDMI_TIMING_FRAME_START_EN
      .vsync       (vsync),
      .frame_start (frame_start)
`else
      .vsync       (vsync)
`endif
   );

   // Predict the registered outputs produced from the current model position.
   task automatic sb_push();
      exp_t e;
      logic act;
      act   = (mh < HA) && (mv < VA);
      e.de  = act;
      e.rgb = act ? (const_mode ? 24'hFF0000 : {12'(mh), 12'(mv)}) : 24'h000000;
      e.hs  = (mh >= HA + HFP) && (mh < HA + HFP + HS);
      e.vs  = (mv >= VA + VFP) && (mv < VA + VFP + VS);
`ifdef HDMI_TIMING_FRAME_START_EN
      e.fs  = (mh == 0) && (mv == 0);
`else
      e.fs  = 1'b0;
`endif
      sbq.push_back(e);
   endtask

   task automatic model_step();
      if (mh == HT - 1) begin
         mh = 0;
         mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
         mh = mh + 1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (de !== 1'b0) begin errors++; $display("FAIL reset_de got=%0b exp=0", de); end
      checks++; if (rgb !== 24'h0) begin errors++; $display("FAIL reset_rgb got=%h exp=000000", rgb); end
      checks++; if (hsync !== 1'b0) begin errors++; $display("FAIL reset_hsync got=%0b exp=0", hsync); end
      checks++; if (vsync !== 1'b0) begin errors++; $display("FAIL reset_vsync got=%0b exp=0", vsync); end
      checks++; if (hcount !== 12'd0) begin errors++; $display("FAIL reset_hcount got=%0d exp=0", hcount); end
      checks++; if (vcount !== 12'd0) begin errors++; $display("FAIL reset_vcount got=%0d exp=0", vcount); end
`ifdef HDMI_TIMING_FRAME_START_EN
      checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs got=%0b exp=0", frame_start); end
`endif
      reset = 1'b0;
      mh = 0;
      mv = 0;
      sbq.delete();
   endtask

   task automatic test_line_frame();
      exp_t e;
      int unsigned de_cnt = 0, hs_cnt = 0, vs_cnt = 0;
      int  de_rise = -1, hs_first = -1, hs_last = -1, hs_prev = -1;
      logic prev_de = 1'b0, prev_hs = 1'b0;
      for (int n = 0; n < int'(2 * FT); n++) begin
         checks++;
         if ({hcount, vcount} !== {12'(mh), 12'(mv)}) begin
            errors++; $display("FAIL frame_coord got=%0d,%0d exp=%0d,%0d", hcount, vcount, mh, mv);
         end
         sb_push();
         @(posedge clk); #1;
         model_step();
         e = sbq.pop_front();
         checks++;
         if (obs !== e) begin
            errors++; $display("FAIL frame_out n=%0d got=%h exp=%h", n, obs, e);
         end
         if (n >= int'(FT)) begin
            if (de) de_cnt++;
            if (hsync) hs_cnt++;
            if (vsync) vs_cnt++;
            if (de && !prev_de && de_rise < 0) de_rise = n;
            if (hsync && !prev_hs) begin
               if (hs_first < 0) hs_first = n;
               hs_prev = hs_last;
               hs_last = n;
            end
         end
         prev_de = de;
         prev_hs = hsync;
      end
      checks++; if (de_cnt != HA * VA) begin errors++; $display("FAIL de_per_frame got=%0d exp=%0d", de_cnt, HA * VA); end
      checks++; if (hs_cnt != HS * VT) begin errors++; $display("FAIL hsync_high got=%0d exp=%0d", hs_cnt, HS * VT); end
      checks++; if (vs_cnt != VS * HT) begin errors++; $display("FAIL vsync_high got=%0d exp=%0d", vs_cnt, VS * HT); end
      checks++; if (hs_last - hs_prev != int'(HT)) begin errors++; $display("FAIL hsync_period got=%0d exp=%0d", hs_last - hs_prev, HT); end
      checks++; if (hs_first - de_rise != int'(HA + HFP)) begin errors++; $display("FAIL hsync_offset got=%0d exp=%0d", hs_first - de_rise, HA + HFP); end
   endtask

   task automatic test_const_color();
      exp_t e;
      const_mode = 1'b1;
      for (int n = 0; n < int'(FT); n++) begin
         sb_push();
         @(posedge clk); #1;
         model_step();
         e = sbq.pop_front();
         checks++;
         if (obs !== e) begin
            errors++; $display("FAIL const_out n=%0d got=%h exp=%h", n, obs, e);
         end
      end
      const_mode = 1'b0;
   endtask

   task automatic test_reset_midframe();
      exp_t e;
      bit   found = 1'b0;
      int unsigned de_cnt = 0;
      for (int n = 0; n < int'(2 * FT); n++) begin
         if (mh == HA + HFP + 1 && mv == 3) begin
            found = 1'b1;
            break;
         end
         sb_push();
         @(posedge clk); #1;
         model_step();
         e = sbq.pop_front();
         checks++;
         if (obs !== e) begin
            errors++; $display("FAIL pre_reset_out n=%0d got=%h exp=%h", n, obs, e);
         end
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL midreset_reach got=0 exp=1");
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++;
      if ({hcount, vcount} !== 24'h0) begin
         errors++; $display("FAIL midreset_coord got=%0d,%0d exp=0,0", hcount, vcount);
      end
      checks++;
      if (obs !== 28'h0) begin
         errors++; $display("FAIL midreset_out got=%h exp=0000000", obs);
      end
      mh = 0;
      mv = 0;
      sbq.delete();
      for (int n = 0; n < int'(FT); n++) begin
         sb_push();
         @(posedge clk); #1;
         model_step();
         e = sbq.pop_front();
         if (de) de_cnt++;
         checks++;
         if (obs !== e) begin
            errors++; $display("FAIL post_reset_out n=%0d got=%h exp=%h", n, obs, e);
         end
      end
      checks++; if (de_cnt != HA * VA) begin errors++; $display("FAIL post_reset_de got=%0d exp=%0d", de_cnt, HA * VA); end
   endtask

`ifdef HDMI_TIMING_FRAME_START_EN
   task automatic test_frame_start();
      exp_t e;
      int   pulses = 0, first = -1, last = -1, prev = -1;
      logic prev_de;
      prev_de = de;
      for (int n = 0; n < int'(3 * FT); n++) begin
         sb_push();
         @(posedge clk); #1;
         model_step();
         e = sbq.pop_front();
         checks++;
         if (obs !== e) begin
            errors++; $display("FAIL fs_out n=%0d got=%h exp=%h", n, obs, e);
         end
         if (frame_start) begin
            pulses++;
            if (first < 0) first = n;
            prev = last;
            last = n;
            checks++;
            if (!(de && !prev_de)) begin
               errors++; $display("FAIL fs_align n=%0d got=de%0b/prev%0b exp=de1/prev0", n, de, prev_de);
            end
         end
         prev_de = de;
      end
      checks++; if (pulses != 3) begin errors++; $display("FAIL fs_count got=%0d exp=3", pulses); end
      checks++; if (last - prev != int'(FT)) begin errors++; $display("FAIL fs_spacing got=%0d exp=%0d", last - prev, FT); end
   endtask
`endif

   initial begin
      test_reset();
      test_line_frame();
      test_const_color();
      test_reset_midframe();
`ifdef HDMI_TIMING_FRAME_START_EN
      test_frame_start();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/hdmi_timing_gen.md
Name: hdmi_timing_gen

Overview:
- Video timing generator for the 1280x720@60 HDMI path (74.25 MHz pixel clock).
- Produces the hcount/vcount scan coordinates consumed by the downstream pattern/colour stage.
- Samples the returned 24-bit pixel and drives registered rgb/de/hsync/vsync to the HDMI encoder, all mutually aligned.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch (clocks)
- H_SYNC, 40, hsync width (clocks)
- H_BP, 220, horizontal back porch (clocks)
- V_ACTIVE, 720, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 20, vertical back porch (lines)
- HS_POL, 1, hsync active level
- VS_POL, 1, vsync active level

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- hcount  out  12  horizontal counter to colour stage
- vcount  out  12  vertical counter to colour stage
- disp_data  in  24  pixel RGB888 returned combinationally for current hcount/vcount
- rgb  out  24  registered pixel to encoder
- de  out  1  registered data enable
- hsync  out  1  registered horizontal sync
- vsync  out  1  registered vertical sync

Behaviour:
- Derived constants: H_TOTAL = sum of H params = 1650; V_TOTAL = sum of V params = 750.
- Internal h_cnt counts 0..H_TOTAL-1. Internal v_cnt counts 0..V_TOTAL-1.
- Regions are ordered active, front porch, sync, back porch, so h_cnt/v_cnt equal pixel coordinates inside the active area.
- hcount = h_cnt and vcount = v_cnt, driven directly from registers with no logic. Raw values are also output during blanking (up to 1649/749); downstream treats out-of-range values as don't-care.
- Wrap:
  - h_cnt == H_TOTAL-1 -> h_cnt <= 0 and v_cnt increments.
  - h_cnt == H_TOTAL-1 and v_cnt == V_TOTAL-1 -> both go to 0 on the same edge.
- active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- Pixel-side register stage, 1 clock latency from hcount/vcount:
  - de <= active
  - rgb <= active ? disp_data : 24'h000000
  - hsync <= (H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC) ? HS_POL : ~HS_POL, i.e. h_cnt in 1390..1429
  - vsync <= (V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC) ? VS_POL : ~VS_POL, i.e. v_cnt in 725..729. vsync spans whole lines and changes only when h_cnt wraps.
- rgb, de, hsync and vsync are always mutually aligned.
- Reset state: h_cnt=0, v_cnt=0, de=0, rgb=0, hsync=~HS_POL, vsync=~VS_POL.
- First cycle after reset deasserts: hcount=0, vcount=0. On the next edge de=1 and rgb = pixel (0,0).
- Reset asserted mid-frame: on the next edge all state returns to reset values, and the frame restarts at (0,0). No partial-line completion.
- disp_data is ignored (rgb forced to 0) whenever active=0.

Optional Feature:
- Macro HDMI_TIMING_FRAME_START_EN.
- When defined: adds output frame_start (1 bit, registered, reset 0). It pulses high for exactly one clock, aligned with de/rgb, on the cycle rgb carries pixel (0,0); the pulse is registered from h_cnt==0 && v_cnt==0.
- When undefined: no port, no logic.

Decomposition:
- Package hdmi_timing_pkg holds:
  - 720p timing defaults and derived H_TOTAL/V_TOTAL
  - RGB width constant (24)
  - typedef for RGB888 pixel
  - counter width constant (12)
- One sub-module is natural: timing_counter, a modulo-N counter with enable, synchronous reset and terminal-count output. It is instantiated twice: horizontal (always enabled) and vertical (enabled by the horizontal terminal count).

Test Plan:
- Reset check: hold reset 3 clocks -> de=0, rgb=0, hsync=0, vsync=0, hcount=0, vcount=0. First de=1 occurs 1 clock after release.
- Line timing:
  - hsync period 1650 clocks, high for 40.
  - hsync rising edge 1390 clocks after the de rising edge.
  - de high for 1280 contiguous clocks per active line.
- Frame timing:
  - vsync period 1,237,500 clocks, high for 5×1650 = 8250 clocks.
  - de count per frame = 921,600.
  - Zero de during lines 720–749.
- Data path and latency: drive disp_data = {hcount, vcount}.
  - rgb == {prev hcount, prev vcount} whenever de=1; rgb=0 whenever de=0.
  - Constant disp_data=24'hFF0000 -> rgb=FF0000 only while de=1.
- Reset mid-frame: assert reset for 1 clock at v_cnt=300, h_cnt=777 -> next cycle counters 0, outputs at reset values; the subsequent frame has full, correct timing.
- HDMI_TIMING_FRAME_START_EN on: over 3 frames, frame_start fires exactly 3 times, each coincident with the first de=1 of the frame, spaced 1,237,500 clocks.
